seg7_scan_driver: RTL and testbench
===================================

// Module: seg7_scan_driver
// PURPOSE
//  Downstream display stage for the stopwatch: takes the four registered BCD digits
//  Hex_0..Hex_3 and drives a 4-digit common-anode 7-segment display by
//  time-multiplexed scanning with an anti-ghosting blank gap.
//  Also provides a lap/freeze function driven by a debounced key pulse from key_stable.
// PARAMETERS
//  IN_CLK_HZ  50_000_000  clk frequency in Hz
//  SCAN_HZ    1000        digit-step rate in Hz; SCAN_DIV = IN_CLK_HZ/SCAN_HZ clk cycles per digit
//  BLANK_CYC  2           clk cycles all digits are off after each digit step (must be < SCAN_DIV-1)
// PORTS
//  clk                input   1  system clock
//  key_reset_cleared  input   1  asynchronous, active-high reset
//  hex_0              input   4  BCD digit 0 (rightmost, S)
//  hex_1              input   4  BCD digit 1 (SS)
//  hex_2              input   4  BCD digit 2 (M)
//  hex_3              input   4  BCD digit 3 (leftmost, MM)
//  lap_pulse          input   1  one-clk pulse (key_stable out); toggles freeze
//  seg_n              output  7  active-low segments {g,f,e,d,c,b,a}
//  dp_n               output  1  active-low decimal point
//  dig_n              output  4  active-low digit enables, bit i = digit i
//  frozen             output  1  1 = display latch held (lap view)
// BEHAVIOUR
//  - Reset (async, immediate, mid-scan included):
//    seg_n=7'h7F, dp_n=1, dig_n=4'hF, frozen=0, scan cnt=0, index=0, latch=0.
//  - Latch: 16-bit display latch {hex_3..hex_0} loads every clk while frozen=0.
//    It holds while frozen=1.
//  - Freeze: lap_pulse=1 toggles frozen on the next edge.
//    - On the entering edge the latch still loads that cycle's inputs (capture).
//    - On leaving, the latch reloads from the next cycle.
//  - Scan counter cnt runs 0..SCAN_DIV-1 and wraps.
//    At cnt==SCAN_DIV-1 (tick), index <= index+1 mod 4 (3->0 wrap).
//  - Blank gap:
//    - dig_n=4'hF while cnt < BLANK_CYC.
//    - Otherwise dig_n = ~(4'b1 << index).
//  - seg_n and dp_n are registered from the latch digit at the current index.
//    They change only while dig_n=4'hF (update on tick).
//  - Decode: 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78,
//    8=7'h00, 9=7'h10. Codes 10..15 show a dash, 7'h3F.
//  - dp_n=0 only for index 2 (separator between M and SS); 1 otherwise.
//  - Output latency: all outputs registered; 1 clk after the internal cnt/index state.
//  - lap_pulse on the same cycle as a tick: both take effect; no ordering dependency.
//  - Inputs are sampled synchronously; they are already clk-domain registers.
// CONFIGURATION
//  LZ_BLANK_EN defined:
//    - Leading-zero blanking: digit 3 shows seg_n=7'h7F when its latched value is 0.
//    - Digit 2 also blanks when digits 3 and 2 are both 0.
//    - Digits 1 and 0 are always shown; dp_n is unaffected.
//  LZ_BLANK_EN undefined: all digits are always decoded; zeros display as 7'h40.
// TESTING  (IN_CLK_HZ=40, SCAN_HZ=4 -> SCAN_DIV=10, BLANK_CYC=2)
//  1. Assert reset mid-scan -> next sample: dig_n=F, seg_n=7F, dp_n=1, frozen=0;
//     after release, index 0 is enabled at cnt=2.
//  2. hex=3,2,1,0 (hex_3..hex_0); run 40 clk ->
//     - dig_n sequence E,D,B,7, each low 8 clk, with 2 clk of F between.
//     - seg_n 40,79,24,30; dp_n=0 only with dig_n=B.
//  3. hex_0=12 -> dash 7'h3F on digit 0; others unaffected.
//  4. lap_pulse with hex=5,9,5,9; then change inputs to 0,0,0,0 ->
//     - frozen=1, display keeps 5,9,5,9.
//     - A second lap_pulse -> frozen=0; shows 0s within one scan.
//  5. lap_pulse on the tick cycle -> index advances and frozen toggles on the same edge.
//  6. LZ_BLANK_EN, hex=0,0,4,7 -> digits 3 and 2 show 7F; digit 1=19, digit 0=78;
//     dp_n is still 0 on index 2.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// Four-digit common-anode 7-segment scanner with anti-ghosting blank gap and lap/freeze latch.
// Optional leading-zero blanking on digits 3/2 is enabled by defining LZ_BLANK_EN.
module seg7_scan_driver #(
    parameter int IN_CLK_HZ = 50_000_000,
    parameter int SCAN_HZ   = 1000,
    parameter int BLANK_CYC = 2
) (
    input  logic       clk,
    input  logic       key_reset_cleared,
    input  logic [3:0] hex_0,
    input  logic [3:0] hex_1,
    input  logic [3:0] hex_2,
    input  logic [3:0] hex_3,
    input  logic       lap_pulse,
    output logic [6:0] seg_n,
    output logic       dp_n,
    output logic [3:0] dig_n,
    output logic       frozen
);
    localparam int SCAN_DIV = IN_CLK_HZ / SCAN_HZ;
    localparam int CW       = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    logic [CW-1:0]   cnt;
    logic [1:0]      index;
    logic [3:0][3:0] latch;
    logic            tick;
    logic            blank;
    logic            seg_upd;
    logic [3:0]      cur_digit;
    logic            lz;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'h40;
            4'd1:    decode = 7'h79;
            4'd2:    decode = 7'h24;
            4'd3:    decode = 7'h30;
            4'd4:    decode = 7'h19;
            4'd5:    decode = 7'h12;
            4'd6:    decode = 7'h02;
            4'd7:    decode = 7'h78;
            4'd8:    decode = 7'h00;
            4'd9:    decode = 7'h10;
            default: decode = 7'h3F;
        endcase
    endfunction

    assign tick      = (cnt == CW'(SCAN_DIV - 1));
    assign blank     = (int'(cnt) < BLANK_CYC);
    // Segment data refreshes only in the gap so a visible digit never changes glyph.
    assign seg_upd   = blank || (cnt == '0);
    assign cur_digit = latch[index];

`ifdef LZ_BLANK_EN
    assign lz = ((index == 2'd3) && (latch[3] == 4'd0)) ||
                ((index == 2'd2) && (latch[3] == 4'd0) && (latch[2] == 4'd0));
`else
    assign lz = 1'b0;
`endif

    always_ff @(posedge clk or posedge key_reset_cleared) begin
        if (key_reset_cleared) begin
            cnt    <= '0;
            index  <= 2'd0;
            latch  <= '0;
            frozen <= 1'b0;
            seg_n  <= 7'h7F;
            dp_n   <= 1'b1;
            dig_n  <= 4'hF;
        end else begin
            cnt   <= tick ? '0 : cnt + 1'b1;
            index <= index + {1'b0, tick};

            // Capture happens on the entering edge because the old frozen value gates it.
            if (!frozen)
                latch <= {hex_3, hex_2, hex_1, hex_0};
            frozen <= frozen ^ lap_pulse;

            dig_n <= blank ? 4'hF : ~(4'b0001 << index);
            if (seg_upd) begin
                seg_n <= lz ? 7'h7F : decode(cur_digit);
                dp_n  <= (index != 2'd2);
            end
        end
    end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver: per-cycle reference model, vector table, lap corner cases.
module tb_seg7_scan_driver;
    localparam int DIV = 10;
    localparam int BLK = 2;

    logic       clk = 1'b0;
    logic       key_reset_cleared = 1'b1;
    logic [3:0] hex_0 = 4'd0, hex_1 = 4'd0, hex_2 = 4'd0, hex_3 = 4'd0;
    logic       lap_pulse = 1'b0;
    logic [6:0] seg_n;
    logic       dp_n;
    logic [3:0] dig_n;
    logic       frozen;

    int total = 0;
    int bad   = 0;

    seg7_scan_driver #(.IN_CLK_HZ(40), .SCAN_HZ(4), .BLANK_CYC(BLK)) dut (
        .clk(clk), .key_reset_cleared(key_reset_cleared),
        .hex_0(hex_0), .hex_1(hex_1), .hex_2(hex_2), .hex_3(hex_3),
        .lap_pulse(lap_pulse), .seg_n(seg_n), .dp_n(dp_n), .dig_n(dig_n), .frozen(frozen)
    );

    always #5 clk = ~clk;

    // Reference model: scan position is derived arithmetically from cycles since reset.
    int         m_t;
    logic [3:0] m_latch [4];
    logic       m_frozen;
    logic [6:0] m_seg;
    logic       m_dp;
    logic [3:0] m_dig;

    localparam logic [6:0] GLYPH [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                          7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
`ifdef LZ_BLANK_EN
    localparam logic [6:0] Z_HI = 7'h7F;
`else
    localparam logic [6:0] Z_HI = 7'h40;
`endif

    function automatic logic [6:0] glyph(input logic [3:0] d);
        return (d > 4'd9) ? 7'h3F : GLYPH[d];
    endfunction

    function automatic logic [6:0] model_seg(input int pos);
        logic blank_it;
        blank_it = 1'b0;
`ifdef LZ_BLANK_EN
        if (pos == 3 && m_latch[3] == 0) blank_it = 1'b1;
        if (pos == 2 && m_latch[3] == 0 && m_latch[2] == 0) blank_it = 1'b1;
`endif
        return blank_it ? 7'h7F : glyph(m_latch[pos]);
    endfunction

    task automatic model_reset();
        m_t = 0;
        for (int i = 0; i < 4; i++) m_latch[i] = 4'd0;
        m_frozen = 1'b0;
        m_seg = 7'h7F;
        m_dp  = 1'b1;
        m_dig = 4'hF;
    endtask

    task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: inputs are already applied; model advances with the same inputs, then compare.
    task automatic step();
        int c, idx;
        @(posedge clk);
        #1;
        c   = m_t % DIV;
        idx = (m_t / DIV) % 4;
        m_dig = (c < BLK) ? 4'hF : ~(4'b0001 << idx);
        if (c < BLK || c == 0) begin
            m_seg = model_seg(idx);
            m_dp  = (idx != 2);
        end
        if (!m_frozen) begin
            m_latch[0] = hex_0; m_latch[1] = hex_1; m_latch[2] = hex_2; m_latch[3] = hex_3;
        end
        m_frozen = m_frozen ^ lap_pulse;
        m_t++;
        chk("dig_n", {3'b0, dig_n}, {3'b0, m_dig});
        chk("seg_n", seg_n, m_seg);
        chk("dp_n", {6'b0, dp_n}, {6'b0, m_dp});
        chk("frozen", {6'b0, frozen}, {6'b0, m_frozen});
    endtask

    logic [6:0] obs_seg [4];
    logic       obs_dp  [4];

    // Run past a full refresh, then record what each enabled digit shows.
    task automatic scan_collect();
        for (int i = 0; i < 4; i++) begin obs_seg[i] = 7'h55; obs_dp[i] = 1'bx; end
        for (int i = 0; i < 60; i++) begin
            step();
            if (i >= 20) begin
                for (int d = 0; d < 4; d++)
                    if (dig_n == ~(4'b0001 << d)) begin obs_seg[d] = seg_n; obs_dp[d] = dp_n; end
            end
        end
    endtask

    typedef struct packed {
        logic [15:0] hex;   // {hex_3,hex_2,hex_1,hex_0}
        logic [27:0] seg;   // {seg3,seg2,seg1,seg0}
    } vec_t;

    vec_t vecs [5];

    task automatic set_hex(input logic [15:0] h);
        {hex_3, hex_2, hex_1, hex_0} = h;
    endtask

    task automatic check_digits(input string tag, input logic [27:0] exp);
        logic [6:0] e;
        for (int d = 0; d < 4; d++) begin
            e = exp[d*7 +: 7];
            chk({tag, "_seg", string'(8'h30 + 8'(d))}, obs_seg[d], e);
            chk({tag, "_dp", string'(8'h30 + 8'(d))}, {6'b0, obs_dp[d]}, {6'b0, (d != 2)});
        end
    endtask

    initial begin
        int cnt_f;
        int idx0;
        vecs[0] = '{hex: 16'h3210, seg: {7'h30, 7'h24, 7'h79, 7'h40}};
        vecs[1] = '{hex: 16'h321C, seg: {7'h30, 7'h24, 7'h79, 7'h3F}};
        vecs[2] = '{hex: 16'h0047, seg: {Z_HI, Z_HI, 7'h19, 7'h78}};
        vecs[3] = '{hex: 16'h0500, seg: {Z_HI, 7'h12, 7'h40, 7'h40}};
        vecs[4] = '{hex: 16'h86FA, seg: {7'h00, 7'h02, 7'h3F, 7'h3F}};

        model_reset();
        #12;
        chk("rst_seg", seg_n, 7'h7F);
        chk("rst_dig", {3'b0, dig_n}, 7'h0F);
        key_reset_cleared = 1'b0;

        // Reset asserted mid-scan takes effect without a clock edge.
        for (int i = 0; i < 17; i++) step();
        #2 key_reset_cleared = 1'b1;
        #1;
        chk("mid_rst_dig", {3'b0, dig_n}, 7'h0F);
        chk("mid_rst_seg", seg_n, 7'h7F);
        chk("mid_rst_dp", {6'b0, dp_n}, 7'h01);
        chk("mid_rst_frz", {6'b0, frozen}, 7'h00);
        #3 key_reset_cleared = 1'b0;
        model_reset();
        step(); step();
        chk("first_gap", {3'b0, dig_n}, 7'h0F);
        step();
        chk("first_dig0", {3'b0, dig_n}, 7'h0E);

        // Blank gap timing: each digit low 8 clk, 2 clk of F between.
        set_hex(16'h3210);
        cnt_f = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (dig_n == 4'hF) cnt_f++;
        end
        chk("gap_count", 7'(cnt_f), 7'd8);

        for (int v = 0; v < 5; v++) begin
            set_hex(vecs[v].hex);
            scan_collect();
            check_digits($sformatf("vec%0d", v), vecs[v].seg);
        end

        // Lap: capture 5,9,5,9, then inputs go to zero while frozen.
        set_hex(16'h5959);
        step(); step();
        lap_pulse = 1'b1; step(); lap_pulse = 1'b0;
        set_hex(16'h0000);
        scan_collect();
        chk("lap_frozen", {6'b0, frozen}, 7'h01);
        check_digits("lap_hold", {7'h12, 7'h10, 7'h12, 7'h10});
        lap_pulse = 1'b1; step(); lap_pulse = 1'b0;
        scan_collect();
        chk("lap_thaw", {6'b0, frozen}, 7'h00);
        check_digits("lap_zero", {Z_HI, Z_HI, 7'h40, 7'h40});

        // Lap pulse on the tick cycle: freeze and index advance share the edge.
        while (m_t % DIV != DIV - 1) step();
        idx0 = (m_t / DIV) % 4;
        lap_pulse = 1'b1; step(); lap_pulse = 1'b0;
        chk("tick_lap_frz", {6'b0, frozen}, 7'h01);
        step(); step(); step();
        chk("tick_lap_idx", {3'b0, dig_n}, {3'b0, ~(4'b0001 << ((idx0 + 1) % 4))});
        lap_pulse = 1'b1; step(); lap_pulse = 1'b0;

        // Randomized traffic against the model.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(7) == 0) begin
                hex_0 = 4'($urandom_range(15)); hex_1 = 4'($urandom_range(15));
                hex_2 = 4'($urandom_range(3));  hex_3 = 4'($urandom_range(2));
            end
            lap_pulse = ($urandom_range(24) == 0);
            step();
        end
        lap_pulse = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
